// File: rtl/seq_divide_if.sv
// Operand/result handshake bundle for seq_divide.
// Handshake: a transfer happens on a rising clk edge where valid && ready; valid holds its payload until then.
interface seq_divide_if #(
  parameter int DW = 20,
  parameter int VW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divide.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// Optional SEQ_DIVIDE_ZERO_DETECT_EN short-circuits divisor==0 to a one-edge result with div_zero set.
module seq_divide #(
  parameter int DW = 20,
  parameter int VW = 10
) (
  input  logic       clk,
  input  logic       rst,
  seq_divide_if.slave bus,
  output logic [1:0] fsm_state
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dsr;
  logic [VW:0]   p;
  logic [CW-1:0] cnt;
  logic          zdet;
  logic [VW:0]   trial;
  logic          q_bit;
  logic [VW:0]   p_next;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign fsm_state     = state;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    trial  = {p[VW-1:0], dvd[DW-1]};
    q_bit  = (trial >= {1'b0, dsr});
    p_next = q_bit ? (trial - {1'b0, dsr}) : trial;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = BUSY;
      BUSY:    if (zdet || (cnt == CW'(1))) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifndef SEQ_DIVIDE_ZERO_DETECT_EN
  assign zdet = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dvd           <= '0;
      dsr           <= '0;
      p             <= '0;
      cnt           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
`ifdef SEQ_DIVIDE_ZERO_DETECT_EN
      zdet          <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            dvd <= bus.dividend;
            dsr <= bus.divisor;
            p   <= '0;
            cnt <= CW'(DW);
`ifdef SEQ_DIVIDE_ZERO_DETECT_EN
            zdet <= (bus.divisor == '0);
`endif
          end
        end
        BUSY: begin
          if (zdet) begin
            bus.quotient  <= '1;
            bus.remainder <= dvd[VW-1:0];
            bus.div_zero  <= 1'b1;
          end else begin
            // Quotient bits fill the dividend register from the bottom as it empties.
            p   <= p_next;
            dvd <= {dvd[DW-2:0], q_bit};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              bus.quotient  <= {dvd[DW-2:0], q_bit};
              bus.remainder <= p_next[VW-1:0];
              bus.div_zero  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/seq_divide.md
Name: seq_divide

Overview:
Iterative restoring unsigned divider, the inverse of the registered sum-product datapath. It recovers one factor from a product and the other factor, e.g. (in1+in2) from the product and (in3+in4).
- Sits on the DSP result path.
- Accepts one operand pair per handshake and produces one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag over a valid/ready output handshake.

Parameters:
DW, 20, dividend and quotient width (matches the 20-bit product width).
VW, 10, divisor and remainder width (matches the 10-bit factor width).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands.
dividend  input  DW  unsigned dividend (product).
divisor  input  VW  unsigned divisor (known factor).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
quotient  output  DW  unsigned quotient.
remainder  output  VW  unsigned remainder.
div_zero  output  1  result came from divisor==0.

Behaviour:
- Reset is asynchronous: clk is rst, asynchronous, active-high. rst forces state IDLE and clears all registered outputs: out_valid=0, quotient=0, remainder=0, div_zero=0. Operand registers, partial remainder and step counter clear to 0.
- in_ready = (state==IDLE), combinational. in_valid is ignored while rst is high.
- FSM states:
  - IDLE -> BUSY on an edge with in_valid&&in_ready. That edge latches dividend, divisor, step count=DW and partial remainder P=0 (VW+1 bits).
  - BUSY, each edge: P = {P[VW-1:0], dividend MSB}; shift the dividend left. If P >= {0,divisor}: P -= divisor and shift 1 into the quotient, else shift 0. Decrement the count.
  - BUSY -> DONE on the edge where count==1, i.e. the DW-th step. That edge loads quotient, remainder = P[VW-1:0] and out_valid=1.
  - DONE -> IDLE on an edge with out_ready. That edge clears out_valid.
- Latency: out_valid rises exactly DW edges after the accepting edge (20 by default). Throughput is one op per DW+2 cycles when out_ready is held high.
- Back-pressure: while out_valid && !out_ready, quotient, remainder and div_zero hold stable and in_ready=0. No new operand is accepted in BUSY or DONE.
- Result fields change only on entry to DONE and hold until the next DONE. Reset clears them.
- Arithmetic: all unsigned. Quotient is the full DW bits. Remainder < divisor whenever divisor != 0.
- Boundary cases:
  - dividend < divisor -> quotient 0, remainder = dividend.
  - dividend = 0 -> quotient 0, remainder 0.
  - divisor = 1 -> quotient = dividend, remainder 0.
  - divisor = 0 (algorithmic result) -> quotient all ones, remainder = dividend[VW-1:0].
- Reset mid-operation: the operation is abandoned immediately and no partial result is presented. The first accept after reset release starts a clean operation.
- in_valid held high after an accept is not re-sampled until the FSM returns to IDLE.

Optional Feature:
Macro SEQ_DIVIDE_ZERO_DETECT_EN.
- Defined: on accept with divisor==0, the FSM goes IDLE -> BUSY for one edge, then directly to DONE.
  - out_valid rises 1 edge after the accepting edge (the next edge).
  - quotient = all ones, remainder = dividend[VW-1:0], div_zero=1.
  - div_zero=0 for every nonzero-divisor result.
- Undefined: no zero check. divisor==0 runs the full DW iterations and yields the same quotient/remainder values. div_zero is tied to 0.

Test Plan:
1. Reset, then accept dividend=200, divisor=7 -> out_valid exactly 20 edges after accept; quotient=28, remainder=4, div_zero=0.
2. Inverse of the sum-product: dividend=150000, divisor=500 -> quotient=300, remainder=0. Also dividend=1048575, divisor=1023 -> quotient=1025, remainder=0.
3. dividend=5, divisor=9 -> quotient=0, remainder=5. Then dividend=0xABCDE, divisor=1 -> quotient=0xABCDE, remainder=0.
4. dividend=1234, divisor=0:
   - with SEQ_DIVIDE_ZERO_DETECT_EN -> out_valid 1 edge after accept; quotient=0xFFFFF, remainder=210, div_zero=1.
   - without it -> same quotient/remainder after 20 edges, div_zero=0.
5. Hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout. Raise out_ready -> out_valid drops next edge and in_ready=1.
6. Assert rst asynchronously mid-BUSY (after step 10 of 200/7) -> all outputs 0 immediately. After release, accept 99/10 -> quotient=9, remainder=9 after 20 edges.
